// File: rtl/first_nios2_system_sysid_checker.sv
// first_nios2_system_sysid_checker: Avalon-MM read master that fetches sysid ID/timestamp and checks them against build values
// Ports: clock/reset (sync, active-high); start pulse; avm_address/avm_read out, avm_readdata/avm_waitrequest in;
//   busy, done pulse, pass, id_ok, ts_ok, timeout, captured_id, captured_ts out.
// Optional feature: define SYSID_CHECK_TIMESTAMP_EN to also read and check the timestamp word (address 1).
module first_nios2_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1363792568,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter int          RETRY_LIMIT    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);
`ifdef SYSID_CHECK_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] RMAX = 4'(RETRY_LIMIT);
  typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, CHECK} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] retry_q, retry_d;
  logic read_q, read_d, addr_q, addr_d, busy_q, busy_d, done_q, done_d;
  logic pass_q, pass_d, id_ok_q, id_ok_d, ts_ok_q, ts_ok_d, timeout_q, timeout_d;
  logic [31:0] cap_id_q, cap_id_d, cap_ts_q, cap_ts_d;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    read_d    = read_q;
    addr_d    = addr_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    id_ok_d   = id_ok_q;
    ts_ok_d   = ts_ok_q;
    timeout_d = timeout_q;
    cap_id_d  = cap_id_q;
    cap_ts_d  = cap_ts_q;
    case (state_q)
      IDLE: if (start) begin
        state_d   = RD_ID;
        {pass_d, id_ok_d, ts_ok_d, timeout_d} = '0;
        cnt_d     = '0;
        retry_d   = '0;
        read_d    = 1'b1;
        addr_d    = 1'b0;
      end
      RD_ID, RD_TS: begin
        // a dropped request (retry gap) lasts exactly one cycle, then is reissued
        if (!read_q) read_d = 1'b1;
        else if (!avm_waitrequest) begin
          if (state_q == RD_ID) cap_id_d = avm_readdata;
          else cap_ts_d = avm_readdata;
          cnt_d   = '0;
          retry_d = '0;
          state_d = (state_q == RD_ID && TS_EN) ? RD_TS : CHECK;
          read_d  = (state_d == RD_TS);
          addr_d  = (state_d == RD_TS);
        end else if (cnt_q == TMAX) begin
          cnt_d     = '0;
          read_d    = 1'b0;
          retry_d   = (retry_q == RMAX) ? retry_q : retry_q + 4'd1;
          timeout_d = (retry_q == RMAX);
          state_d   = (retry_q == RMAX) ? CHECK : state_q;
          addr_d    = (retry_q == RMAX) ? 1'b0 : addr_q;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: begin
        id_ok_d = ~timeout_q & (cap_id_q == EXPECTED_ID);
        ts_ok_d = ~timeout_q & (TS_EN ? (cap_ts_q == EXPECTED_TS) : 1'b1);
        pass_d  = id_ok_d & ts_ok_d;
        done_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      retry_q   <= '0;
      read_q    <= 1'b0;
      addr_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      id_ok_q   <= 1'b0;
      ts_ok_q   <= 1'b0;
      timeout_q <= 1'b0;
      cap_id_q  <= '0;
      cap_ts_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      read_q    <= read_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      id_ok_q   <= id_ok_d;
      ts_ok_q   <= ts_ok_d;
      timeout_q <= timeout_d;
      cap_id_q  <= cap_id_d;
      cap_ts_q  <= cap_ts_d;
    end
  end
  assign avm_read    = read_q;
  assign avm_address = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = timeout_q;
  assign captured_id = cap_id_q;
  assign captured_ts = cap_ts_q;
endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// tb_first_nios2_system_sysid_checker: directed self-checking bench for the sysid checker
module tb_first_nios2_system_sysid_checker;
`ifdef SYSID_CHECK_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  localparam int LAT = TS_EN ? 4 : 3;
  localparam logic [31:0] GOOD_TS = 32'd1363792568;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, wr = 1'b0, start_t = 1'b0, wr_t = 1'b1;
  logic [31:0] id_val = 32'd0, ts_val = GOOD_TS, readdata;
  logic avm_address, avm_read, busy, done, pass, id_ok, ts_ok, timeout;
  logic [31:0] captured_id, captured_ts;
  logic addr_t, read_t, busy_t, done_t, pass_t, id_ok_t, ts_ok_t, timeout_t;
  logic [31:0] cid_t, cts_t;
  int n_pass = 0, n_total = 0;
  int lat, acc_n, a1_seen, glitch;
  logic [3:0] acc_seq;
  assign readdata = avm_address ? ts_val : id_val;
  always #5 clock = ~clock;
  first_nios2_system_sysid_checker dut (
    .clock(clock), .reset(reset), .start(start), .avm_address(avm_address), .avm_read(avm_read),
    .avm_readdata(readdata), .avm_waitrequest(wr), .busy(busy), .done(done), .pass(pass),
    .id_ok(id_ok), .ts_ok(ts_ok), .timeout(timeout), .captured_id(captured_id), .captured_ts(captured_ts)
  );
  first_nios2_system_sysid_checker #(.TIMEOUT_CYCLES(4), .RETRY_LIMIT(2)) dut_t (
    .clock(clock), .reset(reset), .start(start_t), .avm_address(addr_t), .avm_read(read_t),
    .avm_readdata(readdata), .avm_waitrequest(wr_t), .busy(busy_t), .done(done_t), .pass(pass_t),
    .id_ok(id_ok_t), .ts_ok(ts_ok_t), .timeout(timeout_t), .captured_id(cid_t), .captured_ts(cts_t)
  );
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  // pulses start, plays a slave that stalls word 0 for wait0 cycles, stops at done or after 200 cycles
  task automatic run(input int wait0);
    int w0;
    logic pr, pa;
    w0 = 0; pr = 1'b0; pa = 1'b0;
    lat = -1; acc_n = 0; acc_seq = '0; a1_seen = 0; glitch = 0;
    start = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      tick;
      start = 1'b0;
      wr = (avm_read && !avm_address) ? (w0 < wait0) : 1'b0;
      if (avm_read && !avm_address) w0++;
      if (avm_read && avm_address) a1_seen = 1;
      if (pr && avm_read && avm_address !== pa) glitch = 1;
      if (avm_read && !wr) begin acc_n++; acc_seq = {acc_seq[2:0], avm_address}; end
      pr = avm_read & wr;
      pa = avm_address;
      if (done) begin lat = i; break; end
    end
    wr = 1'b0;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) tick;
    n_total++; if ({avm_read, avm_address, busy, done, pass, id_ok, ts_ok, timeout} !== 8'h00) $display("FAIL reset_flags got %b want 00000000", {avm_read, avm_address, busy, done, pass, id_ok, ts_ok, timeout}); else n_pass++;
    n_total++; if ({captured_id, captured_ts} !== 64'd0) $display("FAIL reset_captures got %h want 0", {captured_id, captured_ts}); else n_pass++;
    n_total++; if ({read_t, addr_t, busy_t, done_t, pass_t, id_ok_t, ts_ok_t, timeout_t} !== 8'h00) $display("FAIL reset_flags_t got %b want 00000000", {read_t, addr_t, busy_t, done_t, pass_t, id_ok_t, ts_ok_t, timeout_t}); else n_pass++;
    reset = 1'b0;
    tick;
  endtask
  task automatic test_zero_wait;
    id_val = 32'd0; ts_val = GOOD_TS;
    run(0);
    n_total++; if (lat !== LAT) $display("FAIL zw_latency got %0d want %0d", lat, LAT); else n_pass++;
    n_total++; if ({pass, id_ok, ts_ok, timeout} !== 4'b1110) $display("FAIL zw_flags got %b want 1110", {pass, id_ok, ts_ok, timeout}); else n_pass++;
    n_total++; if (acc_n !== (TS_EN ? 2 : 1)) $display("FAIL zw_reads got %0d want %0d", acc_n, TS_EN ? 2 : 1); else n_pass++;
    n_total++; if (acc_seq !== (TS_EN ? 4'b0001 : 4'b0000)) $display("FAIL zw_addr_seq got %b want %b", acc_seq, TS_EN ? 4'b0001 : 4'b0000); else n_pass++;
    n_total++; if (a1_seen !== int'(TS_EN)) $display("FAIL zw_addr1_seen got %0d want %0d", a1_seen, TS_EN); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL zw_busy_with_done got %b want 0", busy); else n_pass++;
    tick;
    n_total++; if ({done, pass} !== 2'b01) $display("FAIL zw_done_pulse got %b want 01", {done, pass}); else n_pass++;
  endtask
  task automatic test_ts_mismatch;
    ts_val = 32'd1363792569;
    run(0);
    n_total++; if ({pass, id_ok, ts_ok, timeout} !== (TS_EN ? 4'b0100 : 4'b1110)) $display("FAIL tsm_flags got %b want %b", {pass, id_ok, ts_ok, timeout}, TS_EN ? 4'b0100 : 4'b1110); else n_pass++;
    n_total++; if (captured_ts !== (TS_EN ? 32'd1363792569 : 32'd0)) $display("FAIL tsm_captured_ts got %0d want %0d", captured_ts, TS_EN ? 32'd1363792569 : 32'd0); else n_pass++;
    ts_val = GOOD_TS;
  endtask
  task automatic test_id_mismatch;
    id_val = 32'h8000_0000;
    run(0);
    n_total++; if ({pass, id_ok, ts_ok, timeout} !== 4'b0010) $display("FAIL idm_flags got %b want 0010", {pass, id_ok, ts_ok, timeout}); else n_pass++;
    n_total++; if (captured_id !== 32'h8000_0000) $display("FAIL idm_captured_id got %h want 80000000", captured_id); else n_pass++;
    id_val = 32'd0;
  endtask
  task automatic test_wait_states;
    run(5);
    n_total++; if (lat !== LAT + 5) $display("FAIL ws_latency got %0d want %0d", lat, LAT + 5); else n_pass++;
    n_total++; if ({pass, id_ok, ts_ok, timeout} !== 4'b1110) $display("FAIL ws_flags got %b want 1110", {pass, id_ok, ts_ok, timeout}); else n_pass++;
    n_total++; if (glitch !== 0) $display("FAIL ws_addr_stable got %0d want 0", glitch); else n_pass++;
  endtask
  task automatic test_timeout;
    logic [15:0] pat;
    int tl;
    pat = '0; tl = -1;
    start_t = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick;
      start_t = 1'b0;
      if (i <= 16) pat = {pat[14:0], read_t};
      if (done_t) begin tl = i; break; end
    end
    n_total++; if (tl !== 16) $display("FAIL to_latency got %0d want 16", tl); else n_pass++;
    n_total++; if (pat !== 16'hF7BC) $display("FAIL to_read_pattern got %h want f7bc", pat); else n_pass++;
    n_total++; if ({pass_t, id_ok_t, ts_ok_t, timeout_t} !== 4'b0001) $display("FAIL to_flags got %b want 0001", {pass_t, id_ok_t, ts_ok_t, timeout_t}); else n_pass++;
    n_total++; if (cid_t !== 32'd0) $display("FAIL to_captured_id got %h want 0", cid_t); else n_pass++;
  endtask
  task automatic test_reset_mid;
    int dn;
    dn = 0;
    id_val = 32'd7;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    n_total++; if ({busy, captured_id} !== {1'b1, 32'd7}) $display("FAIL rm_before got %b/%0d want 1/7", busy, captured_id); else n_pass++;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    n_total++; if ({avm_read, avm_address, busy, done, pass, id_ok, ts_ok, timeout} !== 8'h00) $display("FAIL rm_flags got %b want 00000000", {avm_read, avm_address, busy, done, pass, id_ok, ts_ok, timeout}); else n_pass++;
    n_total++; if (captured_id !== 32'd0) $display("FAIL rm_captured_id got %0d want 0", captured_id); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (done) dn++;
    end
    n_total++; if (dn !== 0) $display("FAIL rm_no_done got %0d want 0", dn); else n_pass++;
    id_val = 32'd0;
    run(0);
    n_total++; if ({lat, pass, id_ok, ts_ok, timeout} !== {LAT, 4'b1110}) $display("FAIL rm_fresh got %0d/%b want %0d/1110", lat, {pass, id_ok, ts_ok, timeout}, LAT); else n_pass++;
  endtask
  task automatic test_start_busy;
    int dn, dc;
    dn = 0; dc = -1;
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick;
      if (done) begin dn++; if (dc < 0) dc = c; end
      start = (c == 1);
    end
    start = 1'b0;
    n_total++; if (dn !== 1) $display("FAIL sb_done_count got %0d want 1", dn); else n_pass++;
    n_total++; if (dc !== LAT) $display("FAIL sb_done_cycle got %0d want %0d", dc, LAT); else n_pass++;
  endtask
  task automatic test_back_to_back;
    run(0);
    run(0);
    n_total++; if (lat !== LAT) $display("FAIL b2b_latency got %0d want %0d", lat, LAT); else n_pass++;
    n_total++; if ({pass, id_ok, ts_ok, timeout} !== 4'b1110) $display("FAIL b2b_flags got %b want 1110", {pass, id_ok, ts_ok, timeout}); else n_pass++;
    tick;
  endtask
  initial begin
    test_reset;
    test_zero_wait;
    test_ts_mismatch;
    test_id_mismatch;
    test_wait_states;
    test_timeout;
    test_reset_mid;
    test_start_busy;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
